// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD timer controller.
package bcd_timer_pkg;

  // Controller state; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // A target digit above 9 can never be shown by the counter.
  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_tick_gen.sv
// Count-step prescaler. Advances only while run is high, so a pause holds its
// phase. tick is a look-ahead: high when the prescaler will sit on its last
// value in the coming cycle, letting the caller register the step pulse.
module bcd_tick_gen #(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned DIV_W    = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [DIV_W-1:0] LastVal = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Next prescaler value: clear wins, otherwise wrap at TICK_DIV-1 while running.
  always_comb begin
    div_d = div_q;
    if (clr) begin
      div_d = '0;
    end else if (run) begin
      div_d = (div_q == LastVal) ? '0 : div_q + DIV_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_d == LastVal);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Start/stop/pause sequencer for the two-digit BCD up/down counter.
// Optional feature: define BCD_TIMER_AUTORELOAD_EN for periodic operation
// (a match pulses done and cnt_rst and keeps running instead of entering DONE).
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned DIV_W    = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       dir,
  input  logic [3:0] target1,
  input  logic [3:0] target0,
  input  logic [3:0] cnt_digit1,
  input  logic [3:0] cnt_digit0,
  output logic       cnt_rst,
  output logic       cnt_en,
  output logic       cnt_up_down,
  output logic       running,
  output logic       done,
  output logic [1:0] state
);

  state_e state_q;
  logic   step_seen_q;
  logic   hit;
  logic   tick;
  logic   tick_clr;
  logic   tick_run;

  // Terminal compare and prescaler control. The compare is only meaningful in
  // the cycle after a step, once the counter digits have settled.
  always_comb begin
    hit = step_seen_q && is_bcd(target1) && is_bcd(target0) &&
          (cnt_digit1 == target1) && (cnt_digit0 == target0) &&
          ((state_q == StRun) || (state_q == StPause));
    tick_run = (state_q == StRun) && !hit && !clear;
    tick_clr = clear || ((state_q == StIdle) && start);
`ifdef BCD_TIMER_AUTORELOAD_EN
    tick_clr = tick_clr || hit;
`endif
  end

  bcd_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .run  (tick_run),
    .tick (tick)
  );

  // Controller FSM with registered counter controls and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_rst     <= 1'b1;
      cnt_en      <= 1'b0;
      cnt_up_down <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      step_seen_q <= 1'b0;
    end else begin
      cnt_rst     <= 1'b0;
      cnt_en      <= 1'b0;
      step_seen_q <= cnt_en;
`ifdef BCD_TIMER_AUTORELOAD_EN
      done        <= 1'b0;
`endif
      if (clear) begin
        state_q     <= StIdle;
        cnt_rst     <= 1'b1;
        running     <= 1'b0;
        done        <= 1'b0;
        step_seen_q <= 1'b0;
      end else if (hit) begin
`ifdef BCD_TIMER_AUTORELOAD_EN
        cnt_rst <= 1'b1;
        done    <= 1'b1;
`else
        state_q <= StDone;
        running <= 1'b0;
        done    <= 1'b1;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q     <= StRun;
              running     <= 1'b1;
              cnt_up_down <= dir;
            end
          end
          StRun: begin
            // A stop cancels a step that would have fired next cycle.
            if (stop) begin
              state_q <= StPause;
              running <= 1'b0;
            end else begin
              cnt_en <= tick;
            end
          end
          StPause: begin
            if (start) begin
              state_q <= StRun;
              running <= 1'b1;
              cnt_en  <= tick;
            end
          end
          StDone: begin
          end
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl with a behavioural two-digit BCD counter attached.
module tb_bcd_timer_ctrl;
  import bcd_timer_pkg::*;

  localparam int unsigned TickDiv = 4;

  logic       clk = 1'b0;
  logic       rst, start, stop, clear, dir;
  logic [3:0] target1, target0, cnt_digit1, cnt_digit0;
  logic       cnt_rst, cnt_en, cnt_up_down, running, done;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  bcd_timer_ctrl #(.TICK_DIV(TickDiv)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .dir         (dir),
    .target1     (target1),
    .target0     (target0),
    .cnt_digit1  (cnt_digit1),
    .cnt_digit0  (cnt_digit0),
    .cnt_rst     (cnt_rst),
    .cnt_en      (cnt_en),
    .cnt_up_down (cnt_up_down),
    .running     (running),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Two-digit BCD up/down counter driven by the controller.
  always_ff @(posedge clk) begin
    if (cnt_rst) begin
      cnt_digit1 <= 4'd0;
      cnt_digit0 <= 4'd0;
    end else if (cnt_en) begin
      if (cnt_up_down) begin
        if (cnt_digit0 == 4'd9) begin
          cnt_digit0 <= 4'd0;
          cnt_digit1 <= (cnt_digit1 == 4'd9) ? 4'd0 : cnt_digit1 + 4'd1;
        end else begin
          cnt_digit0 <= cnt_digit0 + 4'd1;
        end
      end else begin
        if (cnt_digit0 == 4'd0) begin
          cnt_digit0 <= 4'd9;
          cnt_digit1 <= (cnt_digit1 == 4'd0) ? 4'd9 : cnt_digit1 - 4'd1;
        end else begin
          cnt_digit0 <= cnt_digit0 - 4'd1;
        end
      end
    end
  end

  // Reference model: counter value as an integer 0..99, RUN-cycle phase
  // counted modulo TickDiv, outputs predicted for the cycle after each edge.
  int m_state, m_phase, m_val;
  bit m_en, m_rst, m_ud, m_run, m_done, m_seen;

  task automatic model_edge(input bit r, input bit st, input bit sp, input bit cl, input bit d,
                            input int t1, input int t0);
    int nv, ns, np;
    bit hit, ndone, nrst, nseen;
    if (r) begin
      m_state = 0; m_phase = 0; m_val = 0; m_en = 0; m_rst = 1; m_ud = 1;
      m_run = 0; m_done = 0; m_seen = 0;
      return;
    end
    nv = m_val;
    if (m_rst) nv = 0;
    else if (m_en) nv = m_ud ? (m_val + 1) % 100 : (m_val + 99) % 100;
    hit = m_seen && t1 <= 9 && t0 <= 9 && m_val == t1 * 10 + t0 &&
          (m_state == 1 || m_state == 2);
    ns = m_state; np = m_phase; nrst = 0; ndone = m_done; nseen = m_en;
`ifdef BCD_TIMER_AUTORELOAD_EN
    ndone = 0;
`endif
    if (cl) begin
      ns = 0; np = 0; nrst = 1; ndone = 0; nseen = 0;
    end else if (hit) begin
`ifdef BCD_TIMER_AUTORELOAD_EN
      np = 0; nrst = 1; ndone = 1;
`else
      ns = 3; ndone = 1;
`endif
    end else if (m_state == 0 && st) begin
      ns = 1; np = 0; m_ud = d;
    end else if (m_state == 1) begin
      np = (np + 1) % TickDiv;
      if (sp) ns = 2;
    end else if (m_state == 2 && st) begin
      ns = 1;
    end
    m_en = (ns == 1) && (np == TickDiv - 1) && !cl;
    m_val = nv; m_state = ns; m_phase = np; m_rst = nrst; m_done = ndone;
    m_seen = nseen; m_run = (ns == 1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {17'd0, state, cnt_rst, cnt_en, cnt_up_down, running, done, cnt_digit1, cnt_digit0};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [1:0] s;
    logic [3:0] d1, d0;
    s  = 2'(m_state);
    d1 = 4'(m_val / 10);
    d0 = 4'(m_val % 10);
    return {17'd0, s, m_rst, m_en, m_ud, m_run, m_done, d1, d0};
  endfunction

  // One clock edge with the given command pulses, then compare against the model.
  task automatic step(input bit st, input bit sp, input bit cl);
    start = st; stop = sp; clear = cl;
    @(posedge clk);
    model_edge(rst, st, sp, cl, dir, int'(target1), int'(target0));
    #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    if (!rst) check("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    bit         st, sp, cl;
    logic [1:0] exp_state;
    bit         exp_en;
    logic [7:0] exp_dig;
    bit         exp_done;
  } vec_t;

  vec_t tbl[17];
  logic [7:0] digs[$];
  logic [7:0] exp_down[3];
  logic [7:0] held, prev;
  int n, bad, wrap, dn, seen_done;

  initial begin
    // Count up to 03 from reset: steps at E0+3, +7, +11, DONE from E0+13.
    tbl[0]  = '{1, 0, 0, 2'd1, 0, 8'h00, 0};
    tbl[1]  = '{0, 0, 0, 2'd1, 0, 8'h00, 0};
    tbl[2]  = '{1, 0, 0, 2'd1, 0, 8'h00, 0};
    tbl[3]  = '{0, 0, 0, 2'd1, 1, 8'h00, 0};
    tbl[4]  = '{0, 0, 0, 2'd1, 0, 8'h01, 0};
    tbl[5]  = '{0, 0, 0, 2'd1, 0, 8'h01, 0};
    tbl[6]  = '{0, 0, 0, 2'd1, 0, 8'h01, 0};
    tbl[7]  = '{0, 0, 0, 2'd1, 1, 8'h01, 0};
    tbl[8]  = '{0, 0, 0, 2'd1, 0, 8'h02, 0};
    tbl[9]  = '{0, 0, 0, 2'd1, 0, 8'h02, 0};
    tbl[10] = '{0, 0, 0, 2'd1, 0, 8'h02, 0};
    tbl[11] = '{0, 0, 0, 2'd1, 1, 8'h02, 0};
    tbl[12] = '{0, 0, 0, 2'd1, 0, 8'h03, 0};
    tbl[13] = '{0, 0, 0, 2'd3, 0, 8'h03, 1};
    tbl[14] = '{1, 0, 0, 2'd3, 0, 8'h03, 1};
    tbl[15] = '{0, 1, 0, 2'd3, 0, 8'h03, 1};
    tbl[16] = '{0, 0, 0, 2'd3, 0, 8'h03, 1};
    exp_down[0] = 8'h99; exp_down[1] = 8'h98; exp_down[2] = 8'h97;

    // Reset: three cycles, then release.
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; dir = 1'b1;
    target1 = 4'd0; target0 = 4'd3;
    repeat (3) step(0, 0, 0);
    rst = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt_rst", 32'(cnt_rst), 32'd1);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_up_down", 32'(cnt_up_down), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    step(0, 0, 0);
    check("rst_cnt_rst_drop", 32'(cnt_rst), 32'd0);
    check("rst_digits", 32'({cnt_digit1, cnt_digit0}), 32'({BCD_ZERO, BCD_ZERO}));

`ifndef BCD_TIMER_AUTORELOAD_EN
    // Count up to target 03, table-driven.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].st, tbl[i].sp, tbl[i].cl);
      check($sformatf("up_row%0d", i),
            32'({state, cnt_en, cnt_digit1, cnt_digit0, done}),
            32'({tbl[i].exp_state, tbl[i].exp_en, tbl[i].exp_dig, tbl[i].exp_done}));
    end

    // Count down through the 00 -> 99 wrap to target 97.
    step(0, 0, 1);
    check("down_clear_state", 32'(state), 32'd0);
    target1 = 4'd9; target0 = 4'd7; dir = 1'b0;
    step(1, 0, 0);
    bad = 0; seen_done = 0;
    for (int i = 0; i < 40 && seen_done == 0; i++) begin
      n = int'(cnt_en);
      step(0, 0, 0);
      if (n != 0) digs.push_back({cnt_digit1, cnt_digit0});
      if (cnt_up_down !== 1'b0) bad++;
      if (done === 1'b1) seen_done = 1;
    end
    check("down_done", 32'(seen_done), 32'd1);
    check("down_dir", 32'(bad), 32'd0);
    check("down_steps", 32'(digs.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("down_dig%0d", i), 32'((digs.size() > i) ? digs[i] : 8'hff),
            32'(exp_down[i]));
`endif

    // Pause and resume with phase preserved.
    step(0, 0, 1);
    target1 = 4'd5; target0 = 4'd0; dir = 1'b1;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    check("pause_state", 32'(state), 32'd2);
    held = {cnt_digit1, cnt_digit0};
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0);
      if (cnt_en !== 1'b0 || {cnt_digit1, cnt_digit0} !== held) bad++;
    end
    check("pause_hold", 32'(bad), 32'd0);
    step(1, 0, 0);
    check("resume_first", 32'({state, cnt_en}), 32'({2'd1, 1'b0}));
    step(0, 0, 0);
    check("resume_second", 32'(cnt_en), 32'd1);
    // Stop in the cycle before a due step: step is withheld, fires right after resume.
    repeat (3) step(0, 0, 0);
    step(0, 1, 0);
    check("due_stop", 32'({state, cnt_en}), 32'({2'd2, 1'b0}));
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    check("due_resume_en", 32'(cnt_en), 32'd1);

    // Clear mid-run at 05.
    n = 0;
    for (int i = 0; i < 200 && n == 0; i++) begin
      step(0, 0, 0);
      if ({cnt_digit1, cnt_digit0} == 8'h05) n = 1;
    end
    check("reach05", 32'(n), 32'd1);
    step(0, 0, 1);
    check("clr_ctrl", 32'({cnt_rst, state, running, cnt_en}), 32'({1'b1, 2'd0, 1'b0, 1'b0}));
    step(0, 0, 0);
    check("clr_digits", 32'({cnt_rst, cnt_digit1, cnt_digit0}), 32'd0);
    step(0, 1, 0);
    check("clr_stop_ignored", 32'(state), 32'd0);

    // Invalid target digit: 150 steps, wrap 99 -> 00, no completion.
    target1 = 4'd0; target0 = 4'hA; dir = 1'b1;
    n = 0; wrap = 0; dn = 0;
    step(1, 0, 0);
    for (int i = 0; i < 700 && n < 150; i++) begin
      prev = {cnt_digit1, cnt_digit0};
      step(0, 0, 0);
      if (cnt_en === 1'b1) n++;
      if (prev == 8'h99 && {cnt_digit1, cnt_digit0} == 8'h00) wrap = 1;
      if (done === 1'b1) dn++;
    end
    step(0, 0, 0);
    check("inv_steps", 32'(n), 32'd150);
    check("inv_wrap", 32'(wrap), 32'd1);
    check("inv_done", 32'(dn), 32'd0);
    check("inv_digits", 32'({cnt_digit1, cnt_digit0}), 32'h50);

`ifdef BCD_TIMER_AUTORELOAD_EN
    // Autoreload with target 02: 01, 02, 00, 01, 02 with a done pulse per period.
    step(0, 0, 1);
    target1 = 4'd0; target0 = 4'd2;
    step(1, 0, 0);
    digs.delete();
    dn = 0; bad = 0; wrap = 0; prev = 8'h00;
    for (int i = 0; i < 60 && digs.size() < 4; i++) begin
      n = int'(cnt_en);
      step(0, 0, 0);
      if (n != 0) digs.push_back({cnt_digit1, cnt_digit0});
      if (done === 1'b1) begin
        dn++;
        if (prev[0]) bad++;
      end
      if (dn > 0 && {cnt_digit1, cnt_digit0} == 8'h00) wrap = 1;
      if (state == 2'd3) bad++;
      prev = {7'd0, done};
    end
    repeat (3) begin
      step(0, 0, 0);
      if (done === 1'b1) dn++;
    end
    check("ar_steps", 32'(digs.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ar_dig%0d", i), 32'((digs.size() > i) ? digs[i] : 8'hff),
            32'((i % 2 == 0) ? 8'h01 : 8'h02));
    check("ar_done_pulses", 32'(dn), 32'd2);
    check("ar_zero_seen", 32'(wrap), 32'd1);
    check("ar_no_done_state", 32'(bad), 32'd0);
`endif

    // Random commands against the model.
    step(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        target1 = 4'($urandom_range(0, 10));
        target0 = 4'($urandom_range(0, 11));
      end
      dir = 1'($urandom_range(0, 1));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Sequencing controller for the two-digit BCD up/down counter. It drives the counter's `rst`, `en` and `up_down` inputs from a programmable tick prescaler and watches the counter's digits for a target value, which turns the counter into a start/stop/pause stopwatch or countdown timer. It sits between the user-control logic (single-cycle command pulses) and the counter instance, and flags completion to the rest of the design.

## Interface

Parameters:
- `TICK_DIV`, default 10: clock cycles per count step. Must be at least 2.
- `DIV_W`, default `$clog2(TICK_DIV)`: width of the prescaler counter.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  single-cycle command: run or resume
- `stop`  in  1  single-cycle command: pause
- `clear`  in  1  single-cycle command: zero the counter and go to IDLE
- `dir`  in  1  direction, 1 = up, 0 = down; latched when `start` is accepted from IDLE
- `target1`, `target0`  in  4 each  terminal-value BCD digits (tens, units)
- `cnt_digit1`, `cnt_digit0`  in  4 each  feedback from the counter outputs
- `cnt_rst`  out  1  drives counter `rst`
- `cnt_en`  out  1  drives counter `en`
- `cnt_up_down`  out  1  drives counter `up_down`
- `running`  out  1  high while in RUN
- `done`  out  1  terminal value reached
- `state`  out  2  current FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation

- All outputs are registered.
- Reset values:
  - `state`=IDLE, `cnt_rst`=1, `cnt_en`=0, `cnt_up_down`=1, `running`=0, `done`=0.
  - Prescaler = 0, `step_seen`=0.
- Command priority is `rst` > `clear` > `stop` > `start`. Commands that are not listed for a state are ignored.
- IDLE:
  - `start` goes to RUN, latches `dir` into `cnt_up_down` and zeroes the prescaler.
- RUN:
  - The prescaler increments every cycle. When it reaches TICK_DIV-1 it wraps to 0 and `cnt_en` is high for that one cycle.
  - `stop` goes to PAUSE and holds the prescaler value.
- PAUSE:
  - `start` returns to RUN and resumes from the held prescaler value. Direction is not re-latched.
- DONE:
  - `done` is high. `start` and `stop` are ignored.
- `clear` in any state:
  - `cnt_rst`=1 for the next cycle, prescaler=0, state goes to IDLE, `done`=0.
- Terminal compare:
  - Evaluated only in the cycle after a `cnt_en` pulse, tracked by the `step_seen` flag. This is when the counter digits have updated.
  - If `{cnt_digit1,cnt_digit0}=={target1,target0}`, state goes to DONE at the next edge and the prescaler freezes.
  - Because of this, starting with the counter already at the target does not complete immediately; it needs a full wrap (100 steps).
- Target digits above 9 never match, so the counter free-runs and wraps indefinitely.
- Target and direction wrap follow the counter: 99 up goes to 00, 00 down goes to 99.

## Timing

- `start` accepted at edge E0. `cnt_en` is high in the cycle following edges E0+TICK_DIV-1, E0+2·TICK_DIV-1, and so on.
- Match latency: the counter updates at the edge that ends the `cnt_en` cycle. The compare happens in the next cycle. `done`/DONE are visible 2 cycles after the `cnt_en` cycle.
- Because TICK_DIV ≥ 2, a compare cycle and a `cnt_en` cycle never coincide.
- Pause preserves phase: total RUN cycles between steps stay exactly TICK_DIV, however the run is split.
- `stop` and a `cnt_en` due in the same cycle: the pause wins and no step is issued. The held prescaler is TICK_DIV-1, so the step fires in the first cycle after resume.
- `clear` concurrent with any event: clear wins and no `cnt_en` is issued that cycle.
- `cnt_rst` is 1 for the first cycle after `rst` deasserts, so the counter is zeroed together with the controller.

## Configuration

- `BCD_TIMER_AUTORELOAD_EN` defined:
  - On a match, `done` is a one-cycle pulse and `cnt_rst` pulses the same cycle.
  - The prescaler restarts at 0 and the state stays RUN, giving periodic operation. DONE is never entered.
- Macro not defined: on a match, state goes to DONE and `done` is held high until `clear` or `rst`.

## Structure

- Package `bcd_timer_pkg`:
  - State typedef (2-bit enum, encodings as above).
  - `BCD_MAX`=4'd9, `BCD_ZERO`=4'd0.
- Sub-module `bcd_tick_gen`:
  - Inputs: `clk`, `rst`, `clr`, `run`.
  - Output: `tick`.
  - Implements the prescaler with hold-on-pause.
- The FSM, direction latch and compare logic live in `bcd_timer_ctrl`.

## Test plan

Bench instantiates the controller together with the real counter, TICK_DIV=4.

- Reset: `rst` for 3 cycles, then release. Expect all reset values above, with `cnt_rst`=1 for one cycle after release and counter digits at 00.
- Count up to target: target 03, `dir`=1, `start` at E0. Expect `cnt_en` in cycles E0+3, +7, +11; digits 01, 02, 03; `done`=1 from cycle E0+13; no further `cnt_en`.
- Count down with wrap: `clear`, target 97, `dir`=0, `start`. Expect digits 99, 98, 97, then DONE; `cnt_up_down`=0 throughout.
- Pause and resume: `stop` 2 cycles after `start`, hold 10 cycles, then `start`. Expect the first `cnt_en` exactly 2 RUN cycles after resume and digits unchanged during PAUSE.
- Clear mid-run: at digits 05, pulse `clear`. Expect `cnt_rst`=1 for one cycle, digits 00, IDLE, `running`=0, and a following `stop` ignored.
- Invalid target or autoreload:
  - Target 0xA: 150 steps, digits wrap 99 to 00, `done` never asserts.
  - With `BCD_TIMER_AUTORELOAD_EN` and target 02: `done` pulses every 2 steps and the digits cycle 01, 02, 00, 01, 02.
